// File: rtl/instruction_decode_buffer.sv
// IF->ID skid stage: 2-entry FIFO that pre-decodes the opcode into inst_type.
// Ports: clk, rst, flush, in_* (valid/ready/instr/pc), out_* (valid/ready/instr/pc/inst_type/illegal).
// Optional macro STALL_CNT_EN adds stall_count (saturating back-pressure cycle count).
module instruction_decode_buffer #(
  parameter int         XLEN         = 32,
  parameter logic [2:0] ILLEGAL_TYPE = 3'b111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_inst_type,
`ifdef STALL_CNT_EN
  output logic [31:0]     stall_count,
`endif
  output logic            out_illegal
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [2:0]      itype;
    logic            illegal;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{
    instr:   32'h0000_0013,
    pc:      '0,
    itype:   3'b000,
    illegal: 1'b0
  };

  entry_t     head;
  entry_t     tail;
  entry_t     new_entry;
  logic [1:0] count;
  logic       push;
  logic       pop;
  logic [2:0] type_d;
  logic       ill_d;

  assign in_ready = (count != 2'd2);
  // A push coinciding with flush is dropped.
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = out_valid & out_ready;

  always_comb begin
    type_d = ILLEGAL_TYPE;
    ill_d  = 1'b0;
    unique case (in_instr[6:0])
      7'b0010011,
      7'b0000011,
      7'b1100111,
      7'b1110011,
      7'b0001111: type_d = 3'b000;
      7'b0100011: type_d = 3'b001;
      7'b1100011: type_d = 3'b010;
      7'b0110111,
      7'b0010111: type_d = 3'b011;
      7'b1101111: type_d = 3'b100;
      // R-type carries no immediate but is a legal encoding.
      7'b0110011: type_d = ILLEGAL_TYPE;
      default:    ill_d  = 1'b1;
    endcase
  end

  assign new_entry = '{
    instr:   in_instr,
    pc:      in_pc,
    itype:   type_d,
    illegal: ill_d
  };

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 2'd0;
      out_valid <= 1'b0;
      head      <= RESET_ENTRY;
      tail      <= '0;
    end else if (flush) begin
      count     <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head      <= new_entry;
            out_valid <= 1'b1;
            count     <= 2'd1;
          end else begin
            tail  <= new_entry;
            count <= 2'd2;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            head  <= tail;
            count <= 2'd1;
          end else begin
            out_valid <= 1'b0;
            count     <= 2'd0;
          end
        end
        // Push+pop only happens at count 1: the new word replaces the head.
        2'b11: head <= new_entry;
        default: ;
      endcase
    end
  end

  assign out_instr     = head.instr;
  assign out_pc        = head.pc;
  assign out_inst_type = head.itype;
  assign out_illegal   = head.illegal;

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 32'd0;
    end else if (out_valid && !out_ready
                 && stall_count != 32'hFFFF_FFFF) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
